// File: rtl/sdpram_be_if.sv
// sdpram_be_if: write, read and status signals of the byte-enable simple dual-port RAM
interface sdpram_be_if #(
  parameter int DATASIZE = 32,
  parameter int ADDRSIZE = 4,
  parameter int BYTESIZE = 8
);
  localparam int NB = DATASIZE / BYTESIZE;
  logic clr;
  logic wr_en;
  logic [NB-1:0] wr_be;
  logic [ADDRSIZE-1:0] wr_addr;
  logic [DATASIZE-1:0] wr_data;
  logic rd_en;
  logic [ADDRSIZE-1:0] rd_addr;
  logic [DATASIZE-1:0] rd_data;
  logic rd_valid;
  logic init_done;
  modport master (
    output clr, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    input rd_data, rd_valid, init_done
  );
  modport slave (
    input clr, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, init_done
  );
endinterface

// File: rtl/sdpram_be.sv
// sdpram_be: single-clock simple dual-port RAM with byte enables, read-during-write policy,
// optional output register and a clear engine that zeroes the array after reset or on clr
module sdpram_be #(
  parameter int DATASIZE = 32,
  parameter int ADDRSIZE = 4,
  parameter int BYTESIZE = 8,
  parameter int OUT_REG = 0,
  parameter int RDW_MODE = 0
) (
  input logic clk,
  input logic rst_n,
  sdpram_be_if.slave bus
);
  localparam int NB = DATASIZE / BYTESIZE;
  localparam int DEPTH = 1 << ADDRSIZE;
  typedef enum logic {INIT, READY} state_t;
  state_t state, state_nx;
  logic [ADDRSIZE-1:0] cnt;
  logic [DATASIZE-1:0] mem [DEPTH];
  logic [DATASIZE-1:0] mask, rword, d1;
  logic we, re, v1;
  always_comb begin
    state_nx = bus.clr ? INIT : (state == INIT && &cnt) ? READY : state;
  end
  // terminal compare on cnt ends INIT before the counter can wrap and rewrite address 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= (state == INIT && !bus.clr) ? cnt + 1'b1 : '0;
    end
  assign we = state == READY && !bus.clr && bus.wr_en;
  assign re = state == READY && bus.rd_en;
  assign bus.init_done = state == READY;
  always_comb begin
    mask = '0;
    for (int i = 0; i < NB; i++) mask[i*BYTESIZE +: BYTESIZE] = {BYTESIZE{bus.wr_be[i]}};
    rword = (RDW_MODE == 0 && we && bus.wr_addr == bus.rd_addr)
          ? (mem[bus.rd_addr] & ~mask) | (bus.wr_data & mask) : mem[bus.rd_addr];
  end
  always_ff @(posedge clk)
    if (state == INIT) mem[cnt] <= '0;
    else
      for (int i = 0; i < NB; i++)
        if (we && bus.wr_be[i]) mem[bus.wr_addr][i*BYTESIZE +: BYTESIZE] <= bus.wr_data[i*BYTESIZE +: BYTESIZE];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= re;
      d1 <= re ? rword : d1;
    end
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATASIZE-1:0] d2;
      logic v2;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          d2 <= v1 ? d1 : d2;
        end
      assign bus.rd_data = d2;
      assign bus.rd_valid = v2;
    end else begin : g_direct
      assign bus.rd_data = d1;
      assign bus.rd_valid = v1;
    end
  endgenerate
endmodule

// File: tb/tb_sdpram_be.sv
// tb_sdpram_be: scoreboard bench driving a write-first/latency-1 and a read-first/latency-2 RAM
// with identical stimulus, checked against an array model of the RAM rules
module tb_sdpram_be;
  typedef struct {logic [31:0] d; int t;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0] wr_be = '0, wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  exp_t q[2][$];
  logic [31:0] last[2];
  logic [31:0] mm[16];
  logic ready = 1'b0;
  int left = 16;
  sdpram_be_if #(.DATASIZE(32), .ADDRSIZE(4), .BYTESIZE(8)) b0 ();
  sdpram_be_if #(.DATASIZE(32), .ADDRSIZE(4), .BYTESIZE(8)) b1 ();
  assign {b0.clr, b0.wr_en, b0.wr_be, b0.wr_addr, b0.wr_data, b0.rd_en, b0.rd_addr} =
         {clr, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr};
  assign {b1.clr, b1.wr_en, b1.wr_be, b1.wr_addr, b1.wr_data, b1.rd_en, b1.rd_addr} =
         {clr, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr};
  sdpram_be #(.DATASIZE(32), .ADDRSIZE(4), .BYTESIZE(8), .OUT_REG(0), .RDW_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  sdpram_be #(.DATASIZE(32), .ADDRSIZE(4), .BYTESIZE(8), .OUT_REG(1), .RDW_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", n, a, e, cyc);
    end
  endtask
  task automatic bad(input string n, input logic [31:0] a);
    n_cmp++;
    n_bad++;
    $display("FAIL %s actual=%h expected=none cycle=%0d", n, a, cyc);
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return (old & ~m) | (wd & m);
  endfunction
  task automatic mon(input int k, input logic v, input logic [31:0] d);
    exp_t e;
    if (v) begin
      if (q[k].size() == 0) bad($sformatf("spurious_valid%0d", k), d);
      else begin
        e = q[k].pop_front();
        chk($sformatf("rd_data%0d", k), d, e.d);
        chk($sformatf("latency%0d", k), cyc, e.t);
      end
      last[k] = d;
    end else begin
      chk($sformatf("hold%0d", k), d, last[k]);
      if (q[k].size() != 0 && q[k][0].t <= cyc) begin
        e = q[k].pop_front();
        chk($sformatf("missing_valid%0d", k), 32'd0, 32'd1);
      end
    end
  endtask
  always @(negedge clk)
    if (rst_n) begin
      mon(0, b0.rd_valid, b0.rd_data);
      mon(1, b1.rd_valid, b1.rd_data);
    end
  task automatic model_reset();
    q[0].delete();
    q[1].delete();
    last[0] = '0;
    last[1] = '0;
    for (int i = 0; i < 16; i++) mm[i] = '0;
    ready = 1'b0;
    left = 16;
  endtask
  task automatic tick(input logic w, input logic [3:0] be, input logic [3:0] wa, input logic [31:0] wd,
                      input logic r, input logic [3:0] ra, input logic c);
    exp_t e;
    {wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr, clr} = {w, be, wa, wd, r, ra, c};
    if (ready && r) begin
      e.d = (w && !c && wa == ra) ? merge(mm[ra], wd, be) : mm[ra];
      e.t = cyc + 1;
      q[0].push_back(e);
      e.d = mm[ra];
      e.t = cyc + 2;
      q[1].push_back(e);
    end
    if (c) begin
      for (int i = 0; i < 16; i++) mm[i] = '0;
      ready = 1'b0;
      left = 16;
    end else if (!ready) begin
      left--;
      ready = left == 0;
    end else if (w) mm[wa] = merge(mm[wa], wd, be);
    @(posedge clk);
    #1;
    chk("init_done0", {31'd0, b0.init_done}, {31'd0, ready});
    chk("init_done1", {31'd0, b1.init_done}, {31'd0, ready});
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    tick(1, be, a, d, 0, 0, 0);
  endtask
  task automatic rd(input logic [3:0] a);
    tick(0, 0, 0, 0, 1, a, 0);
  endtask
  task automatic reset_now();
    #2;
    rst_n = 1'b0;
    {wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr, clr} = '0;
    #1;
    chk("rst_valid0", {31'd0, b0.rd_valid}, 32'd0);
    chk("rst_valid1", {31'd0, b1.rd_valid}, 32'd0);
    chk("rst_data0", b0.rd_data, 32'd0);
    chk("rst_data1", b1.rd_data, 32'd0);
    chk("rst_init0", {31'd0, b0.init_done}, 32'd0);
    chk("rst_init1", {31'd0, b1.init_done}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data0", b0.rd_data, 32'd0);
    chk("rst_init1", {31'd0, b1.init_done}, 32'd0);
    rst_n = 1'b1;
    idle(17);
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(3);
    wr(3, 32'hAABBCCDD, 4'hF);
    wr(3, 32'h11223344, 4'b0101);
    rd(3);
    tick(1, 4'b0011, 5, 32'hDEADBEEF, 1, 5, 0);
    rd(5);
    idle(3);
    for (int a = 0; a < 16; a++) wr(4'(a), 32'h5A000000 | 32'(a * 32'h01010101 + 1), 4'hF);
    tick(1, 4'hF, 7, 32'hCAFEF00D, 0, 0, 1);
    for (int i = 0; i < 16; i++) tick(0, 0, 0, 0, 1, 4'($urandom_range(15)), 0);
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(3);
    reset_now();
    idle(8);
    reset_now();
    idle(16);
    for (int a = 0; a < 16; a++) wr(4'(a), $urandom, 4'hF);
    rd(2);
    reset_now();
    idle(16);
    for (int a = 0; a < 16; a++) wr(4'(a), $urandom, 4'($urandom_range(15)));
    for (int a = 0; a < 16; a++) rd(4'(a));
    for (int i = 0; i < 500; i++) begin
      logic [3:0] wa;
      wa = 4'($urandom_range(15));
      tick(1'($urandom_range(1)), 4'($urandom_range(15)), wa, $urandom, 1'($urandom_range(1)),
           $urandom_range(1) != 0 ? wa : 4'($urandom_range(15)), $urandom_range(59) == 0);
    end
    idle(4);
    chk("drain0", q[0].size(), 32'd0);
    chk("drain1", q[1].size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
